// File: rtl/ucode_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : ucode_seq_if
// Description : Bundle between the microcode sequencer, decode (launch),
//               the micro-op ROM and the EXE stage control inputs.
//               master = sequencer side, slave = decode/ROM/EXE side.
// Revision    : 1.0 - initial release
// ============================================================================
interface ucode_seq_if #(
    parameter int ADDR_W = 8
);
    // Launch from decode
    logic              start;
    logic [ADDR_W-1:0] entry_addr;
    // Micro-ROM port
    logic [ADDR_W-1:0] rom_addr;
    logic [31:0]       rom_word;
    // EXE control and feedback
    logic              branch_taken;
    logic [2:0]        alu_instruct;
    logic              rom_reg_read;
    logic              flag_set;
    logic              shift_en;
    logic              alu_en;
    logic [3:0]        b_cond;
    // Status
    logic              busy;
    logic              done;
    logic              fault;

    modport master (
        input  start, entry_addr, rom_word, branch_taken,
        output rom_addr, alu_instruct, rom_reg_read, flag_set, shift_en,
               alu_en, b_cond, busy, done, fault
    );

    modport slave (
        output start, entry_addr, rom_word, branch_taken,
        input  rom_addr, alu_instruct, rom_reg_read, flag_set, shift_en,
               alu_en, b_cond, busy, done, fault
    );
endinterface
`default_nettype wire

// File: rtl/ucode_seq.sv
`default_nettype none
// ============================================================================
// Module      : ucode_seq
// Description : EXE-stage microcode sequencer. Walks the synchronous
//               micro-op ROM (FETCH/EXEC per micro-word), drives the EXE
//               controls during EXEC, and selects the next address as
//               SEQ / JMP / JT (branch taken) / LOOP (8-bit loop counter).
//               Optional step watchdog enabled by defining UCSEQ_WATCHDOG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module ucode_seq #(
    parameter int ADDR_W    = 8,
    parameter int MAX_STEPS = 255
) (
    input  logic        clk,
    input  logic        rst,
    ucode_seq_if.master ucif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2
    } state_t;

    localparam logic [1:0] C_NXT_SEQ  = 2'b00;
    localparam logic [1:0] C_NXT_JMP  = 2'b01;
    localparam logic [1:0] C_NXT_JT   = 2'b10;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [7:0]        loop_cnt_q, loop_cnt_d;
    logic              done_q, done_d;

`ifdef UCSEQ_WATCHDOG_EN
    localparam logic [7:0] C_MAX_STEPS = 8'(MAX_STEPS);
    logic [7:0]        step_q, step_d;
    logic              fault_q, fault_d;
`endif

    // Micro-word fields
    logic              w_end;
    logic [1:0]        w_next;
    logic [ADDR_W-1:0] w_target;
    logic [7:0]        w_count;
    logic              w_load;
    logic [7:0]        w_cnt_eff;
    logic [ADDR_W-1:0] w_seq_addr;
    logic              unused_rsv;

    assign w_end      = ucif.rom_word[7];
    assign w_next     = ucif.rom_word[9:8];
    assign w_target   = ADDR_W'(ucif.rom_word[21:14]);
    assign w_count    = ucif.rom_word[29:22];
    assign w_load     = ucif.rom_word[30];
    assign unused_rsv = ucif.rom_word[31];

    // A load in this word takes effect before the LOOP test of the same word
    assign w_cnt_eff  = w_load ? w_count : loop_cnt_q;
    assign w_seq_addr = rom_addr_q + ADDR_W'(1);

    // State, address, loop counter and status registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rom_addr_q <= '0;
            loop_cnt_q <= '0;
            done_q     <= 1'b0;
`ifdef UCSEQ_WATCHDOG_EN
            step_q     <= '0;
            fault_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            rom_addr_q <= rom_addr_d;
            loop_cnt_q <= loop_cnt_d;
            done_q     <= done_d;
`ifdef UCSEQ_WATCHDOG_EN
            step_q     <= step_d;
            fault_q    <= fault_d;
`endif
        end
    end

    // Next-state, next-address and loop-counter selection
    always_comb begin
        state_d    = state_q;
        rom_addr_d = rom_addr_q;
        loop_cnt_d = loop_cnt_q;
        done_d     = 1'b0;
`ifdef UCSEQ_WATCHDOG_EN
        step_d     = step_q;
        fault_d    = 1'b0;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (ucif.start) begin
                    state_d    = S_FETCH;
                    rom_addr_d = ucif.entry_addr;
`ifdef UCSEQ_WATCHDOG_EN
                    step_d     = '0;
`endif
                end
            end
            S_FETCH: begin
                state_d = S_EXEC;
            end
            S_EXEC: begin
                loop_cnt_d = w_cnt_eff;
                if (w_end) begin
                    // Next field ignored; address holds on the last word
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_FETCH;
                    case (w_next)
                        C_NXT_SEQ: rom_addr_d = w_seq_addr;
                        C_NXT_JMP: rom_addr_d = w_target;
                        C_NXT_JT:  rom_addr_d = ucif.branch_taken ? w_target
                                                                  : w_seq_addr;
                        default: begin
                            if (w_cnt_eff != 8'd0) begin
                                loop_cnt_d = w_cnt_eff - 8'd1;
                                rom_addr_d = w_target;
                            end else begin
                                rom_addr_d = w_seq_addr;
                            end
                        end
                    endcase
                end
`ifdef UCSEQ_WATCHDOG_EN
                step_d = step_q + 8'd1;
                if (!w_end && (step_d == C_MAX_STEPS)) begin
                    state_d    = S_IDLE;
                    fault_d    = 1'b1;
                    loop_cnt_d = '0;
                end
`endif
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // EXE controls: decoded from the ROM word only during EXEC, else zero
    always_comb begin
        ucif.alu_instruct = 3'b000;
        ucif.rom_reg_read = 1'b0;
        ucif.flag_set     = 1'b0;
        ucif.shift_en     = 1'b0;
        ucif.alu_en       = 1'b0;
        ucif.b_cond       = 4'h0;
        if (state_q == S_EXEC) begin
            ucif.alu_instruct = ucif.rom_word[2:0];
            ucif.rom_reg_read = ucif.rom_word[3];
            ucif.flag_set     = ucif.rom_word[4];
            ucif.shift_en     = ucif.rom_word[5];
            ucif.alu_en       = ucif.rom_word[6];
            ucif.b_cond       = ucif.rom_word[13:10];
        end
    end

    assign ucif.rom_addr = rom_addr_q;
    assign ucif.busy     = (state_q != S_IDLE);
    assign ucif.done     = done_q;
`ifdef UCSEQ_WATCHDOG_EN
    assign ucif.fault    = fault_q;
`else
    assign ucif.fault    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ucode_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_ucode_seq
// Description : Self-checking bench for ucode_seq: single-word decode and
//               next-address vectors, plus straight-line, loop, collision,
//               mid-run reset and watchdog sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ucode_seq;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    ucode_seq_if #(.ADDR_W(8)) bus ();

    ucode_seq #(.ADDR_W(8), .MAX_STEPS(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .ucif (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous micro-op ROM model
    logic [31:0] rom [256];
    always @(posedge clk) bus.rom_word <= rom[bus.rom_addr];

    // Micro-word builder: {rsv, load, count, target, bcond, next, end, ctl[6:0]}
    function automatic logic [31:0] mk(input logic e, input logic [1:0] nx,
                                       input logic [7:0] tgt, input logic [7:0] cnt,
                                       input logic ld, input logic [3:0] bc,
                                       input logic [6:0] ctl);
        return {1'b0, ld, cnt, tgt, bc, nx, e, ctl};
    endfunction

    // Observed controls as {alu[2:0], rr, fs, sh, ae, bcond[3:0]}
    function automatic logic [10:0] ctl_act();
        return {bus.alu_instruct, bus.rom_reg_read, bus.flag_set,
                bus.shift_en, bus.alu_en, bus.b_cond};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk({tag, "_rst_addr"},  32'(bus.rom_addr), 32'h0);
        chk({tag, "_rst_busy"},  32'(bus.busy),     32'h0);
        chk({tag, "_rst_done"},  32'(bus.done),     32'h0);
        chk({tag, "_rst_fault"}, 32'(bus.fault),    32'h0);
        chk({tag, "_rst_ctl"},   32'(ctl_act()),    32'h0);
    endtask

    task automatic launch(input logic [7:0] a);
        bus.start      = 1'b1;
        bus.entry_addr = a;
        tick();
        bus.start      = 1'b0;
    endtask

    typedef struct {
        logic [7:0]  entry;
        logic [31:0] word;
        logic        taken;
        logic [10:0] ctl;   // {alu, rr, fs, sh, ae, bcond}
        logic [7:0]  nxt;
        logic        dn;
    } vec_t;

    vec_t vt [9];

    // Absolute time bound so the run always terminates
    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] exp_addr [8];
        logic       exp_busy [8];
        logic       exp_done [8];
        int         busy_cycles;

        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.entry_addr = 8'h00;
        bus.branch_taken = 1'b0;
        for (int i = 0; i < 256; i++) rom[i] = 32'h0;

        // Single-word vectors: entry, word, taken, expected controls, next addr, done
        vt[0] = '{8'h40, mk(1'b0, 2'b00, 8'h00, 8'd0, 1'b0, 4'h0, 7'b1000101) | 32'h8000_0000,
                  1'b0, {3'd5, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0}, 8'h41, 1'b0};
        vt[1] = '{8'h50, mk(1'b0, 2'b01, 8'h77, 8'd0, 1'b0, 4'hA, 7'b0101010),
                  1'b0, {3'd2, 1'b1, 1'b0, 1'b1, 1'b0, 4'hA}, 8'h77, 1'b0};
        vt[2] = '{8'h20, mk(1'b0, 2'b10, 8'h30, 8'd0, 1'b0, 4'h3, 7'b0010000),
                  1'b1, {3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h3}, 8'h30, 1'b0};
        vt[3] = '{8'h20, mk(1'b0, 2'b10, 8'h30, 8'd0, 1'b0, 4'h3, 7'b0010000),
                  1'b0, {3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h3}, 8'h21, 1'b0};
        vt[4] = '{8'hFF, mk(1'b0, 2'b00, 8'h00, 8'd0, 1'b0, 4'h0, 7'b0000000),
                  1'b0, 11'h000, 8'h00, 1'b0};
        vt[5] = '{8'h60, mk(1'b1, 2'b01, 8'h11, 8'd0, 1'b0, 4'hF, 7'b1111111),
                  1'b0, {3'd7, 1'b1, 1'b1, 1'b1, 1'b1, 4'hF}, 8'h60, 1'b1};
        vt[6] = '{8'h70, mk(1'b0, 2'b11, 8'h05, 8'd0, 1'b0, 4'h0, 7'b0000001),
                  1'b0, {3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0}, 8'h71, 1'b0};
        vt[7] = '{8'h70, mk(1'b0, 2'b11, 8'h05, 8'd2, 1'b1, 4'h0, 7'b0000001),
                  1'b0, {3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0}, 8'h05, 1'b0};
        vt[8] = '{8'h70, mk(1'b0, 2'b11, 8'h05, 8'd0, 1'b1, 4'h0, 7'b0000001),
                  1'b0, {3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0}, 8'h71, 1'b0};

        for (int i = 0; i < 9; i++) begin
            do_reset($sformatf("vec%0d", i));
            rom[vt[i].entry] = vt[i].word;
            bus.branch_taken = vt[i].taken;
            launch(vt[i].entry);
            chk($sformatf("vec%0d_fetch_addr", i), 32'(bus.rom_addr), 32'(vt[i].entry));
            chk($sformatf("vec%0d_fetch_busy", i), 32'(bus.busy), 32'h1);
            chk($sformatf("vec%0d_fetch_ctl", i), 32'(ctl_act()), 32'h0);
            tick();
            chk($sformatf("vec%0d_exec_ctl", i), 32'(ctl_act()), 32'(vt[i].ctl));
            tick();
            chk($sformatf("vec%0d_next_addr", i), 32'(bus.rom_addr), 32'(vt[i].nxt));
            chk($sformatf("vec%0d_done", i), 32'(bus.done), 32'(vt[i].dn));
            chk($sformatf("vec%0d_busy", i), 32'(bus.busy), 32'(!vt[i].dn));
        end
        bus.branch_taken = 1'b0;

        // Straight line 0x10..0x12, start while busy ignored, start on done cycle
        do_reset("line");
        rom[8'h10] = mk(1'b0, 2'b00, 8'h00, 8'd0, 1'b0, 4'h0, 7'h41);
        rom[8'h11] = mk(1'b0, 2'b00, 8'h00, 8'd0, 1'b0, 4'h0, 7'h42);
        rom[8'h12] = mk(1'b1, 2'b00, 8'h00, 8'd0, 1'b0, 4'h0, 7'h43);
        exp_addr = '{8'h10, 8'h10, 8'h11, 8'h11, 8'h12, 8'h12, 8'h12, 8'h10};
        exp_busy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        exp_done = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        launch(8'h10);
        for (int c = 1; c <= 8; c++) begin
            chk($sformatf("line_c%0d_addr", c), 32'(bus.rom_addr), 32'(exp_addr[c-1]));
            chk($sformatf("line_c%0d_busy", c), 32'(bus.busy), 32'(exp_busy[c-1]));
            chk($sformatf("line_c%0d_done", c), 32'(bus.done), 32'(exp_done[c-1]));
            if (c == 3) begin
                bus.start = 1'b1;
                bus.entry_addr = 8'h99;
            end else if (c == 7) begin
                bus.start = 1'b1;
                bus.entry_addr = 8'h10;
            end else begin
                bus.start = 1'b0;
            end
            if (c < 8) tick();
        end
        bus.start = 1'b0;

        // Counted loop: load 3 at 0x80 looping to 0x81, 0x81 loops on itself, 0x82 ends
        do_reset("loop");
        rom[8'h80] = mk(1'b0, 2'b11, 8'h81, 8'd3, 1'b1, 4'h0, 7'h40);
        rom[8'h81] = mk(1'b0, 2'b11, 8'h81, 8'd0, 1'b0, 4'h0, 7'h40);
        rom[8'h82] = mk(1'b1, 2'b00, 8'h00, 8'd0, 1'b0, 4'h0, 7'h00);
        launch(8'h80);
        busy_cycles = 0;
        while (bus.busy && busy_cycles < 40) begin
            busy_cycles++;
            tick();
        end
        chk("loop_busy_cycles", 32'(busy_cycles), 32'd10);
        chk("loop_done", 32'(bus.done), 32'h1);
        chk("loop_end_addr", 32'(bus.rom_addr), 32'h82);
        tick();
        chk("loop_done_pulse", 32'(bus.done), 32'h0);

        // Reset during EXEC of the loop word, then verify counter was cleared
        do_reset("midrst");
        launch(8'h80);
        tick();
        tick();
        tick();
        chk("midrst_exec_addr", 32'(bus.rom_addr), 32'h81);
        chk("midrst_exec_alu_en", 32'(bus.alu_en), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy", 32'(bus.busy), 32'h0);
        chk("midrst_addr", 32'(bus.rom_addr), 32'h0);
        chk("midrst_ctl", 32'(ctl_act()), 32'h0);
        chk("midrst_done", 32'(bus.done), 32'h0);
        launch(8'h81);
        tick();
        tick();
        chk("midrst_cnt_zero_next", 32'(bus.rom_addr), 32'h82);

        // Infinite JMP-to-self
        do_reset("wdog");
        rom[8'h90] = mk(1'b0, 2'b01, 8'h90, 8'd0, 1'b0, 4'h0, 7'h00);
        launch(8'h90);
        for (int c = 1; c <= 12; c++) begin
`ifdef UCSEQ_WATCHDOG_EN
            chk($sformatf("wdog_c%0d_fault", c), 32'(bus.fault), 32'(c == 9));
            chk($sformatf("wdog_c%0d_busy", c), 32'(bus.busy), 32'(c <= 8));
`else
            chk($sformatf("wdog_c%0d_fault", c), 32'(bus.fault), 32'h0);
            chk($sformatf("wdog_c%0d_busy", c), 32'(bus.busy), 32'h1);
`endif
            chk($sformatf("wdog_c%0d_done", c), 32'(bus.done), 32'h0);
            tick();
        end
        do_reset("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
